miriscv_instr_prefetch_buffer: RTL and testbench

Sits between the fetch unit and instruction memory, directly upstream of fetch. It streams sequential word fetches into a small FIFO ahead of the core's requests, so sequential fetches hit with a one-cycle registered response. On an address mismatch or a kill it discards stale data and restarts the stream at the requested PC.

---
 rtl/miriscv_pkg.sv | 16 +
 rtl/miriscv_sync_fifo.sv | 67 ++++++
 rtl/miriscv_instr_prefetch_buffer.sv | 124 ++++++++++++
 tb/tb_miriscv_instr_prefetch_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_pkg.sv
// Shared core definitions: datapath widths, the canonical NOP encoding
// and the prefetch buffer's default depth and stream states.
package miriscv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned ILEN     = 32;
   localparam logic [31:0] NOP      = 32'h00000013;
   localparam int unsigned PF_DEPTH = 4;

   // Prefetch stream control: idle (no fetching) or streaming from pf_addr.
   typedef enum logic {
      PF_IDLE,
      PF_STREAM
   } pf_state_e;

endpackage

// File: rtl/miriscv_sync_fifo.sv
// Small synchronous FIFO with a synchronous clear and a first-word
// fall-through head. DEPTH must be a power of two so pointers wrap naturally.
module miriscv_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           wdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [WIDTH-1:0]           rdata
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Status flags, qualified push/pop strobes and the head word.
   always_comb begin
      full    = (count == FULL_COUNT);
      empty   = (count == '0);
      do_push = push & (~full | pop);
      do_pop  = pop & ~empty;
      rdata   = storage[rd_ptr];
   end

   // Pointer and occupancy tracking; clear wins over a same-cycle push.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Data storage; not reset since occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (do_push && !clear) storage[wr_ptr] <= wdata;
   end

   // The upstream issue limit must never let a push reach a full FIFO.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !clear) begin
         assert (!(push && full && !pop));
      end
   end

endmodule

// File: rtl/miriscv_instr_prefetch_buffer.sv
// Instruction prefetch buffer: streams sequential word fetches into a FIFO
// ahead of the fetch unit, answering sequential requests with a one-cycle
// registered response and restarting the stream on a mismatch or kill.
module miriscv_instr_prefetch_buffer #(
   parameter int unsigned DEPTH = miriscv_pkg::PF_DEPTH,
   parameter int unsigned XLEN  = miriscv_pkg::XLEN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            core_req_i,
   input  logic [XLEN-1:0] core_addr_i,
   input  logic            core_flush_i,
   output logic            core_rvalid_o,
   output logic [XLEN-1:0] core_rdata_o,
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_addr_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   import miriscv_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

   pf_state_e       state;
   logic [XLEN-1:0] pf_addr;
   logic [XLEN-1:0] head_addr;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;

   logic [CW-1:0]   fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic [XLEN-1:0] fifo_head;

   logic [CW:0]     in_use;
   logic            grant;
   logic            resp_push;
   logic            resp_drop;
   logic            req_live;
   logic            addr_match;
   logic            hit;
   logic            miss;
   logic            redirect;
   logic            fifo_clear;
   logic [CW-1:0]   outstanding_nxt;
   logic [XLEN-1:0] target_addr;
   logic            unused_addr_lsbs;

   // Issue gating, response routing and hit/miss classification.
   always_comb begin
      in_use     = {1'b0, fifo_count} + {1'b0, outstanding};
      mem_req_o  = (state == PF_STREAM) && (in_use < LIMIT) && !fifo_full;
      mem_addr_o = pf_addr;
      grant      = mem_req_o & mem_gnt_i;
      resp_drop  = mem_rvalid_i & (discard != '0);
      resp_push  = mem_rvalid_i & (discard == '0);

      req_live   = (state == PF_STREAM) & core_req_i & ~core_rvalid_o & ~core_flush_i;
      addr_match = (core_addr_i[XLEN-1:2] == head_addr[XLEN-1:2]);
      hit        = req_live & addr_match & ~fifo_empty;
      miss       = req_live & ~addr_match;
      redirect   = ~core_flush_i & core_req_i & ((state == PF_IDLE) | miss);
      fifo_clear = redirect | core_flush_i;

      // Every request still in flight after this edge (including a grant
      // landing on the redirect edge itself) belongs to the old stream.
      outstanding_nxt = outstanding + CW'(grant) - CW'(mem_rvalid_i);

      target_addr      = {core_addr_i[XLEN-1:2], 2'b00};
      unused_addr_lsbs = ^core_addr_i[1:0];
   end

   // Stream FSM, address/credit counters and the registered core response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= PF_IDLE;
         pf_addr       <= '0;
         head_addr     <= '0;
         outstanding   <= '0;
         discard       <= '0;
         core_rvalid_o <= 1'b0;
         core_rdata_o  <= XLEN'(NOP);
      end else begin
         outstanding   <= outstanding_nxt;
         core_rvalid_o <= hit;
         if (hit) begin
            core_rdata_o <= fifo_head;
            head_addr    <= head_addr + XLEN'(4);
         end
         if (grant)     pf_addr <= pf_addr + XLEN'(4);
         if (resp_drop) discard <= discard - CW'(1);

         if (core_flush_i) begin
            state   <= PF_IDLE;
            discard <= outstanding_nxt;
         end else if (redirect) begin
            state     <= PF_STREAM;
            discard   <= outstanding_nxt;
            pf_addr   <= target_addr;
            head_addr <= target_addr;
         end
      end
   end

   miriscv_sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (resp_push),
      .pop   (hit),
      .clear (fifo_clear),
      .wdata (mem_rdata_i),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .rdata (fifo_head)
   );

endmodule

// File: tb/tb_miriscv_instr_prefetch_buffer.sv
// Self-checking bench: a randomised memory responder plus a word-level
// reference (each address maps to a fixed hash word) drive the fetch port.
module tb_miriscv_instr_prefetch_buffer;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP_W = 32'h00000013;

   logic        clk;
   logic        rst_i;
   logic        core_req_i;
   logic [31:0] core_addr_i;
   logic        core_flush_i;
   logic        core_rvalid_o;
   logic [31:0] core_rdata_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   miriscv_instr_prefetch_buffer #(
      .DEPTH (DEPTH),
      .XLEN  (32)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .core_req_i    (core_req_i),
      .core_addr_i   (core_addr_i),
      .core_flush_i  (core_flush_i),
      .core_rvalid_o (core_rvalid_o),
      .core_rdata_o  (core_rdata_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc = 0;
   int unsigned inv_viol = 0;
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;
   int unsigned gnt_pct = 100;
   bit          prev_rv = 1'b0;

   logic [31:0] pend_a [$];
   int unsigned pend_d [$];
   logic [31:0] glog   [$];

   // Memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] mw(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E3779B1) ^ 32'h5BD1E995;
   endfunction

   // Decide memory inputs for the coming edge (called at the negedge).
   task automatic mem_drive();
      if (rst_i) begin
         pend_a.delete();
         pend_d.delete();
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = $urandom;
         return;
      end
      if (pend_a.size() > 0 && pend_d[0] <= cyc + 1) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = mw(pend_a[0]);
         void'(pend_a.pop_front());
         void'(pend_d.pop_front());
      end else begin
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = $urandom;
      end
      mem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
      if (mem_req_o && mem_gnt_i) begin
         pend_a.push_back(mem_addr_o);
         pend_d.push_back(cyc + 1 + $urandom_range(lat_min, lat_max));
         glog.push_back(mem_addr_o);
      end
      if (pend_a.size() > DEPTH) inv_viol++;
   endtask

   task automatic tick();
      mem_drive();
      @(negedge clk);
      cyc++;
      if (core_rvalid_o && prev_rv) inv_viol++;
      prev_rv = core_rvalid_o;
      if (mem_req_o && mem_addr_o[1:0] != 2'b00) inv_viol++;
   endtask

   // Hold a request until the response, then drop it for the response cycle.
   task automatic fetch(input logic [31:0] a, output int unsigned lat,
                        output logic [31:0] data, output bit ok);
      core_req_i  = 1'b1;
      core_addr_i = a;
      lat  = 0;
      data = '0;
      ok   = 1'b0;
      for (int unsigned i = 1; i <= 200; i++) begin
         tick();
         if (core_rvalid_o) begin
            lat  = i;
            data = core_rdata_o;
            ok   = 1'b1;
            break;
         end
      end
      core_req_i = 1'b0;
      if (ok) tick();
   endtask

   task automatic test_reset();
      rst_i = 1'b1; core_req_i = 1'b0; core_flush_i = 1'b0; core_addr_i = '0;
      repeat (3) tick();
      n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b expected 0", mem_req_o); end
      n_cmp++; if (mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h expected 00000000", mem_addr_o); end
      n_cmp++; if (core_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b expected 0", core_rvalid_o); end
      n_cmp++; if (core_rdata_o !== NOP_W) begin n_bad++; $display("FAIL reset_rdata: got %h expected %h", core_rdata_o, NOP_W); end
      rst_i = 1'b0;
      repeat (3) tick();
      n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL idle_mem_req: got %b expected 0", mem_req_o); end
   endtask

   task automatic test_first_fetch();
      int unsigned lat; logic [31:0] d; bit ok;
      lat_min = 1; lat_max = 1; gnt_pct = 100;
      glog.delete();
      fetch(32'h100, lat, d, ok);
      n_cmp++; if (!ok || lat != 4) begin n_bad++; $display("FAIL first_latency: got %0d expected 4", lat); end
      n_cmp++; if (d !== mw(32'h100)) begin n_bad++; $display("FAIL first_data: got %h expected %h", d, mw(32'h100)); end
      repeat (10) tick();
      for (int unsigned i = 0; i < 4; i++) begin
         n_cmp++;
         if (glog.size() <= i || glog[i] !== 32'h100 + 4 * i) begin
            n_bad++; $display("FAIL first_req_addr[%0d]: got %h expected %h", i, glog[i], 32'h100 + 4 * i);
         end
      end
      // One word consumed, DEPTH more held: DEPTH+1 grants in total.
      n_cmp++; if (glog.size() != DEPTH + 1) begin n_bad++; $display("FAIL first_req_count: got %0d expected %0d", glog.size(), DEPTH + 1); end
   endtask

   task automatic test_sequential();
      int unsigned lat; logic [31:0] d; bit ok;
      for (int unsigned i = 1; i <= 2; i++) begin
         fetch(32'h100 + 4 * i, lat, d, ok);
         n_cmp++; if (!ok || lat != 1) begin n_bad++; $display("FAIL seq_latency[%0d]: got %0d expected 1", i, lat); end
         n_cmp++; if (d !== mw(32'h100 + 4 * i)) begin n_bad++; $display("FAIL seq_data[%0d]: got %h expected %h", i, d, mw(32'h100 + 4 * i)); end
      end
      repeat (10) tick();
      n_cmp++; if (glog.size() != 7) begin n_bad++; $display("FAIL seq_refill_count: got %0d expected 7", glog.size()); end
      n_cmp++; if (glog.size() < 7 || glog[6] !== 32'h118) begin n_bad++; $display("FAIL seq_refill_addr: got %h expected 00000118", glog[6]); end
   endtask

   task automatic test_miss();
      int unsigned lat; logic [31:0] d; bit ok;
      lat_min = 5; lat_max = 5; gnt_pct = 100;
      fetch(32'h10C, lat, d, ok);
      n_cmp++; if (!ok || d !== mw(32'h10C)) begin n_bad++; $display("FAIL miss_pre0_data: got %h expected %h", d, mw(32'h10C)); end
      fetch(32'h110, lat, d, ok);
      n_cmp++; if (!ok || d !== mw(32'h110)) begin n_bad++; $display("FAIL miss_pre1_data: got %h expected %h", d, mw(32'h110)); end
      n_cmp++; if (pend_a.size() != 2) begin n_bad++; $display("FAIL miss_inflight: got %0d expected 2", pend_a.size()); end
      glog.delete();
      fetch(32'h200, lat, d, ok);
      n_cmp++; if (!ok || lat != 8) begin n_bad++; $display("FAIL miss_latency: got %0d expected 8", lat); end
      n_cmp++; if (d !== mw(32'h200)) begin n_bad++; $display("FAIL miss_data: got %h expected %h", d, mw(32'h200)); end
      n_cmp++; if (glog.size() == 0 || glog[0] !== 32'h200) begin n_bad++; $display("FAIL miss_first_req: got %h expected 00000200", glog[0]); end
   endtask

   task automatic test_flush();
      int unsigned lat; logic [31:0] d; bit ok; bit saw_rv; bit saw_req;
      lat_min = 1; lat_max = 1; gnt_pct = 100;
      repeat (12) tick();
      core_req_i = 1'b1; core_addr_i = 32'h204; core_flush_i = 1'b1;
      tick();
      core_req_i = 1'b0; core_flush_i = 1'b0;
      n_cmp++; if (core_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL flush_rvalid: got %b expected 0", core_rvalid_o); end
      n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL flush_mem_req: got %b expected 0", mem_req_o); end
      saw_rv = 1'b0; saw_req = 1'b0;
      repeat (8) begin
         tick();
         saw_rv  = saw_rv  | core_rvalid_o;
         saw_req = saw_req | mem_req_o;
      end
      n_cmp++; if (saw_rv) begin n_bad++; $display("FAIL flush_idle_rvalid: got 1 expected 0"); end
      n_cmp++; if (saw_req) begin n_bad++; $display("FAIL flush_idle_req: got 1 expected 0"); end
      lat_min = 1; lat_max = 5; gnt_pct = 80;
      glog.delete();
      fetch(32'h300, lat, d, ok);
      n_cmp++; if (!ok || d !== mw(32'h300)) begin n_bad++; $display("FAIL flush_restart_data: got %h expected %h", d, mw(32'h300)); end
      n_cmp++; if (glog.size() == 0 || glog[0] !== 32'h300) begin n_bad++; $display("FAIL flush_restart_req: got %h expected 00000300", glog[0]); end
   endtask

   task automatic test_random();
      int unsigned lat; logic [31:0] d; bit ok; logic [31:0] a;
      lat_min = 1; lat_max = 5; gnt_pct = 70; inv_viol = 0;
      a = 32'h304;
      for (int unsigned n = 0; n < 200; n++) begin
         if ($urandom_range(0, 99) < 30) a = 32'h2000 + ($urandom_range(0, 255) << 2);
         fetch(a | 32'($urandom_range(0, 3)), lat, d, ok);
         n_cmp++;
         if (!ok || d !== mw(a)) begin
            n_bad++; $display("FAIL random_data[%0d] addr %h: got %h expected %h", n, a, d, mw(a));
         end
         repeat ($urandom_range(0, 2)) tick();
         a = a + 4;
      end
      n_cmp++; if (inv_viol != 0) begin n_bad++; $display("FAIL random_invariants: got %0d violations expected 0", inv_viol); end
   endtask

   task automatic test_wrap_and_reset();
      int unsigned lat; logic [31:0] d; bit ok;
      lat_min = 1; lat_max = 1; gnt_pct = 100;
      repeat (20) tick();
      glog.delete();
      fetch(32'hFFFFFFF8, lat, d, ok);
      n_cmp++; if (!ok || lat != 4 || d !== mw(32'hFFFFFFF8)) begin n_bad++; $display("FAIL wrap_first: got lat %0d data %h expected lat 4 data %h", lat, d, mw(32'hFFFFFFF8)); end
      n_cmp++;
      if (glog.size() < 3 || glog[0] !== 32'hFFFFFFF8 || glog[1] !== 32'hFFFFFFFC || glog[2] !== 32'h0) begin
         n_bad++; $display("FAIL wrap_req_seq: got %h %h %h expected fffffff8 fffffffc 00000000", glog[0], glog[1], glog[2]);
      end
      fetch(32'hFFFFFFFC, lat, d, ok);
      n_cmp++; if (!ok || lat != 1 || d !== mw(32'hFFFFFFFC)) begin n_bad++; $display("FAIL wrap_second: got lat %0d data %h expected lat 1 data %h", lat, d, mw(32'hFFFFFFFC)); end
      fetch(32'h0, lat, d, ok);
      n_cmp++; if (!ok || lat != 1 || d !== mw(32'h0)) begin n_bad++; $display("FAIL wrap_zero: got lat %0d data %h expected lat 1 data %h", lat, d, mw(32'h0)); end
      // Reset lands on a cycle that would otherwise return a hit.
      core_req_i = 1'b1; core_addr_i = 32'h4; rst_i = 1'b1;
      tick();
      n_cmp++;
      if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || core_rvalid_o !== 1'b0 || core_rdata_o !== NOP_W) begin
         n_bad++; $display("FAIL midreset_outputs: got req %b addr %h rv %b data %h expected 0 00000000 0 %h",
                           mem_req_o, mem_addr_o, core_rvalid_o, core_rdata_o, NOP_W);
      end
      rst_i = 1'b0; core_req_i = 1'b0;
      tick();
      fetch(32'h40, lat, d, ok);
      n_cmp++; if (!ok || lat != 4 || d !== mw(32'h40)) begin n_bad++; $display("FAIL post_reset_fetch: got lat %0d data %h expected lat 4 data %h", lat, d, mw(32'h40)); end
      n_cmp++; if (inv_viol != 0) begin n_bad++; $display("FAIL final_invariants: got %0d violations expected 0", inv_viol); end
   endtask

   initial begin
      rst_i = 1'b1; core_req_i = 1'b0; core_addr_i = '0; core_flush_i = 1'b0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      test_reset();
      test_first_fetch();
      test_sequential();
      test_miss();
      test_flush();
      test_random();
      test_wrap_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
